// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: FSM controller for the shift-add sequential multiplier datapath.
//   clk          rising-edge clock
//   Reset        synchronous, active-high; forces IDLE and iter_cnt=0
//   start        operation request, accepted only while ready=1
//   lsb          current product/multiplier LSB from the datapath
//   ready        idle, able to accept start
//   mcand_load   multiplicand load (high) / run (low)
//   mplier_load  load multiplier into product low half
//   prod_clear   clear product high half
//   alu_add      product_hi += multiplicand (gated by lsb)
//   shift        shift product right by one
//   done         one-cycle pulse, product valid
//   iter_cnt     completed iterations, saturates at WIDTH
// Define MUL_SINGLE_CYCLE_STEP_EN to merge add and shift into one STEP state.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             lsb,
  output logic             ready,
  output logic             mcand_load,
  output logic             mplier_load,
  output logic             prod_clear,
  output logic             alu_add,
  output logic             shift,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifdef MUL_SINGLE_CYCLE_STEP_EN
  typedef enum logic [2:0] {IDLE, LOAD, STEP, DONE} state_t;
  state_t state;
  always_ff @(posedge clk)
    if (Reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else
      case (state)
        IDLE: state <= start ? LOAD : IDLE;
        LOAD: begin
          state    <= STEP;
          iter_cnt <= '0;
        end
        STEP: begin
          state    <= iter_cnt == LAST ? DONE : STEP;
          iter_cnt <= iter_cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
  assign alu_add = state == STEP && lsb;
  assign shift   = state == STEP;
`else
  typedef enum logic [2:0] {IDLE, LOAD, CALC, SHIFT, DONE} state_t;
  state_t state;
  always_ff @(posedge clk)
    if (Reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else
      case (state)
        IDLE: state <= start ? LOAD : IDLE;
        LOAD: begin
          state    <= CALC;
          iter_cnt <= '0;
        end
        CALC: state <= SHIFT;
        SHIFT: begin
          state    <= iter_cnt == LAST ? DONE : CALC;
          iter_cnt <= iter_cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
  assign alu_add = state == CALC && lsb;
  assign shift   = state == SHIFT;
`endif
  assign ready       = state == IDLE;
  assign mcand_load  = state == LOAD;
  assign mplier_load = state == LOAD;
  assign prod_clear  = state == LOAD;
  assign done        = state == DONE;
endmodule
